control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Moore-style hardwired control unit that sits directly upstream of the mini-CPU datapath.
- Steps fetch / decode / execute microsteps and drives every bus out-select, register in-enable, ALU op and memory strobe the datapath consumes.
- Holds the fetched IR locally.
- Handshakes with memory via mem_ready, with a timeout.

Parameters:
- OP_W, 5, ALU op / opcode width.
- NREG, 16, general registers R0..R15.
- MEM_TIMEOUT, 15, max cycles to wait for mem_ready before error.

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  synchronous active-high reset
- run  in  1  level; 0 = hold at next instruction boundary
- ir_in  in  32  instruction word from MDR/bus, captured when IRin asserted
- mem_ready  in  1  memory access complete (one-cycle pulse or level)
- reg_out  out  16  one-hot Rxout
- reg_in  out  16  one-hot Rxin
- HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout, Cout  out  1 each  bus sources
- HIin, LOin, Zin, PCin, MDRin, MARin, IRin, Yin  out  1 each  sinks; Zin drives both Zhighin and Zlowin
- op  out  5  ALU operation
- Read, Write  out  1  memory strobes
- c_sext  out  32  sign-extended IR[18:0] for the Cout source
- halted  out  1  in HALT state
- mem_err  out  1  sticky timeout flag

Behaviour:
- Reset and output timing
  - clear has priority at any state, including mid-access: go to T0 next edge; IR=0, timeout count=0, mem_err=0.
  - All outputs are combinational from state+IR; in reset cycle all are 0.
- IR fields: opc=IR[31:27], Ra=[26:23], Rb=[22:19], Rc=[18:15], C=[18:0].
- Opcodes:
  - ld=00000, st=00010, add=00011, sub=00100, and=00101, or=00110, mul=01111, div=10000, nop=11000, halt=11011.
  - Any other opcode is executed as nop.
- ALU ops:
  - op=opc for add/sub/and/or/mul/div.
  - INC=10110 (Z=B+1).
  - ld/st address computation uses op=add.
- Fetch:
  - T0: PCout, MARin, op=INC, Zin.
  - T1: Zlowout, PCin, Read, MDRin; hold in T1 until mem_ready.
  - T2: MDRout, IRin; IR latched.
- Execute, R-type (add/sub/and/or):
  - T3: Rb out, Yin.
  - T4: Rc out, op, Zin.
  - T5: Zlowout, Ra in.
  - Then boundary.
- Execute, mul/div:
  - T3: Ra out, Yin.
  - T4: Rb out, op, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin.
- Execute, ld:
  - T3: Rb out, Yin.
  - T4: Cout, op=add, Zin.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin; wait mem_ready.
  - T7: MDRout, Ra in.
- Execute, st:
  - T3–T5 as ld.
  - T6: Ra out, MDRin (Read=0).
  - T7: Write; wait mem_ready.
- nop: boundary immediately after T2. halt: enter HALT; halted=1, all strobes 0; exit only by clear.
- Boundary:
  - If run=1, next state is T0; else stay in IDLE (all outputs 0) until run=1.
  - run is sampled only at the boundary.
- Timeout:
  - While waiting in a memory state, a counter increments each cycle.
  - When the counter reaches MEM_TIMEOUT without mem_ready: set mem_err and go to HALT.
  - mem_ready on the same cycle as the limit wins.
- Invariants:
  - Exactly one bus source asserted in any cycle, or none.
  - reg_out/reg_in are one-hot or zero.
  - Ra/Rb/Rc==0 selects R0 normally.

Optional Feature:
- SINGLE_STEP_EN
  - Defined: adds input step (1-bit). At each instruction boundary the sequencer enters PAUSE and advances to T0 only on a cycle with step=1 (and run=1); holding step high executes one instruction per boundary.
  - Undefined: no step port; boundary behaviour as above.

Decomposition:
- Package cpu_ctrl_pkg:
  - opcode constants, ALU op constants incl. INC;
  - state enum (IDLE, T0..T7, HALT, PAUSE);
  - IR field position localparams.
- Sub-module ir_decode:
  - combinational: IR to opc, one-hot Ra/Rb/Rc (4→16 decoders), c_sext, instruction-class flags.

Test Plan:
- Reset mid-T6 of ld (clear=1 one cycle) → next state T0, all strobes 0 during clear cycle, mem_err=0.
- add R3,R1,R2 with mem_ready asserted 2 cycles after Read → T1 holds 2 cycles; then sequence T3 reg_out=0x0002+Yin, T4 reg_out=0x0004+op=00011+Zin, T5 Zlowout+reg_in=0x0008; 8 cycles total after fetch start.
- ld R5, 0x40(R2) (IR=0x02900040) → T4 Cout with c_sext=0x00000040, op=00011; T7 MDRout and reg_in=0x0020.
- st with C=0x7FFFF sign bit set case (C=0x40000) → c_sext=0xFFFC0000; T7 Write held until mem_ready.
- mem_ready never asserted after Read in T1 → after 15 cycles mem_err=1, halted=1, stays until clear.
- opcode 11111 → treated as nop, back to T0 after T2; opcode 11011 → halted=1; run=0 at boundary → IDLE, all outputs 0, resumes T0 on run=1.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcodes, ALU ops, states, IR field positions and control-word type
package cpu_ctrl_pkg;

    localparam int CPU_OP_W        = 5;
    localparam int CPU_NREG        = 16;
    localparam int CPU_MEM_TIMEOUT = 15;

    // Instruction field positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;
    localparam int C_HI   = 18;

    // Opcodes
    localparam logic [CPU_OP_W-1:0] OPC_LD   = 5'b00000;
    localparam logic [CPU_OP_W-1:0] OPC_ST   = 5'b00010;
    localparam logic [CPU_OP_W-1:0] OPC_ADD  = 5'b00011;
    localparam logic [CPU_OP_W-1:0] OPC_SUB  = 5'b00100;
    localparam logic [CPU_OP_W-1:0] OPC_AND  = 5'b00101;
    localparam logic [CPU_OP_W-1:0] OPC_OR   = 5'b00110;
    localparam logic [CPU_OP_W-1:0] OPC_MUL  = 5'b01111;
    localparam logic [CPU_OP_W-1:0] OPC_DIV  = 5'b10000;
    localparam logic [CPU_OP_W-1:0] OPC_NOP  = 5'b11000;
    localparam logic [CPU_OP_W-1:0] OPC_HALT = 5'b11011;

    // ALU operations beyond the ones that reuse the opcode value
    localparam logic [CPU_OP_W-1:0] ALU_ADD = OPC_ADD;
    localparam logic [CPU_OP_W-1:0] ALU_INC = 5'b10110;

    typedef enum logic [3:0] {
        IDLE,
        T0,
        T1,
        T2,
        T3,
        T4,
        T5,
        T6,
        T7,
        HALT,
        PAUSE
    } state_e;

    // One cycle's worth of datapath control
    typedef struct packed {
        logic [CPU_NREG-1:0] reg_out;
        logic [CPU_NREG-1:0] reg_in;
        logic                hi_out;
        logic                lo_out;
        logic                zhigh_out;
        logic                zlow_out;
        logic                pc_out;
        logic                mdr_out;
        logic                inport_out;
        logic                y_out;
        logic                c_out;
        logic                hi_in;
        logic                lo_in;
        logic                z_in;
        logic                pc_in;
        logic                mdr_in;
        logic                mar_in;
        logic                ir_in;
        logic                y_in;
        logic [CPU_OP_W-1:0] op;
        logic                read;
        logic                write;
    } ctrl_t;

endpackage

// File: rtl/ir_decode.sv
// rtl/ir_decode.sv - combinational IR field decode: opcode, one-hot register selects, sign-extended C, class flags
module ir_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [31:0]          ir_i,
    output logic [CPU_OP_W-1:0]  opc_o,
    output logic [CPU_NREG-1:0]  ra_oh_o,
    output logic [CPU_NREG-1:0]  rb_oh_o,
    output logic [CPU_NREG-1:0]  rc_oh_o,
    output logic [31:0]          c_sext_o,
    output logic                 is_rtype_o,
    output logic                 is_muldiv_o,
    output logic                 is_ld_o,
    output logic                 is_st_o,
    output logic                 is_halt_o
);

    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;

    assign opc_o = ir_i[OPC_HI:OPC_LO];
    assign ra    = ir_i[RA_HI:RA_LO];
    assign rb    = ir_i[RB_HI:RB_LO];
    assign rc    = ir_i[RC_HI:RC_LO];

    assign ra_oh_o  = CPU_NREG'(1) << ra;
    assign rb_oh_o  = CPU_NREG'(1) << rb;
    assign rc_oh_o  = CPU_NREG'(1) << rc;
    assign c_sext_o = {{(31 - C_HI){ir_i[C_HI]}}, ir_i[C_HI:0]};

    // Classify the opcode; anything unrecognised falls through as a nop
    always_comb begin
        is_rtype_o  = 1'b0;
        is_muldiv_o = 1'b0;
        is_ld_o     = 1'b0;
        is_st_o     = 1'b0;
        is_halt_o   = 1'b0;
        case (opc_o)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: is_rtype_o  = 1'b1;
            OPC_MUL, OPC_DIV:                  is_muldiv_o = 1'b1;
            OPC_LD:                            is_ld_o     = 1'b1;
            OPC_ST:                            is_st_o     = 1'b1;
            OPC_HALT:                          is_halt_o   = 1'b1;
            default:                           ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/decode/execute sequencer; SINGLE_STEP_EN adds a step input and PAUSE boundary
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W        = CPU_OP_W,
    parameter int NREG        = CPU_NREG,
    parameter int MEM_TIMEOUT = CPU_MEM_TIMEOUT
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             run,
`ifdef SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic [31:0]      ir_in,
    input  logic             mem_ready,
    output logic [NREG-1:0]  reg_out,
    output logic [NREG-1:0]  reg_in,
    output logic             HIout,
    output logic             LOout,
    output logic             Zhighout,
    output logic             Zlowout,
    output logic             PCout,
    output logic             MDRout,
    output logic             InPortout,
    output logic             Yout,
    output logic             Cout,
    output logic             HIin,
    output logic             LOin,
    output logic             Zin,
    output logic             PCin,
    output logic             MDRin,
    output logic             MARin,
    output logic             IRin,
    output logic             Yin,
    output logic [OP_W-1:0]  op,
    output logic             Read,
    output logic             Write,
    output logic [31:0]      c_sext,
    output logic             halted,
    output logic             mem_err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    state_e           boundary_next;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_err_q, mem_err_d;
    logic             mem_wait;
    logic             timeout;
    logic             step_go;
    logic [31:0]      ir_cur;
    ctrl_t            ctl;

    logic [CPU_OP_W-1:0] opc;
    logic [CPU_NREG-1:0] ra_oh, rb_oh, rc_oh;
    logic [31:0]         dec_c_sext;
    logic                is_rtype, is_muldiv, is_ld, is_st, is_halt;

    // During T2 the word being latched decides the branch, so decode it directly
    assign ir_cur = (state_q == T2) ? ir_in : ir_q;

    ir_decode u_ir_decode (
        .ir_i        (ir_cur),
        .opc_o       (opc),
        .ra_oh_o     (ra_oh),
        .rb_oh_o     (rb_oh),
        .rc_oh_o     (rc_oh),
        .c_sext_o    (dec_c_sext),
        .is_rtype_o  (is_rtype),
        .is_muldiv_o (is_muldiv),
        .is_ld_o     (is_ld),
        .is_st_o     (is_st),
        .is_halt_o   (is_halt)
    );

`ifdef SINGLE_STEP_EN
    assign boundary_next = PAUSE;
    assign step_go       = step & run;
`else
    assign boundary_next = run ? T0 : IDLE;
    assign step_go       = 1'b0;
`endif

    // State, IR, wait counter and sticky error; clear wins over everything
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= T0;
            ir_q      <= '0;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Next-state sequencing including memory waits and timeout escape to HALT
    always_comb begin
        state_d  = state_q;
        mem_wait = 1'b0;
        case (state_q)
            IDLE:  state_d = run ? T0 : IDLE;
            PAUSE: state_d = step_go ? T0 : PAUSE;
            T0:    state_d = T1;
            T1: begin
                mem_wait = 1'b1;
                if (mem_ready) state_d = T2;
            end
            T2: begin
                if (is_halt)                                   state_d = HALT;
                else if (is_rtype || is_muldiv || is_ld || is_st) state_d = T3;
                else                                           state_d = boundary_next;
            end
            T3:    state_d = T4;
            T4:    state_d = T5;
            T5:    state_d = is_rtype ? boundary_next : T6;
            T6: begin
                if (is_ld) begin
                    mem_wait = 1'b1;
                    if (mem_ready) state_d = T7;
                end else if (is_st) begin
                    state_d = T7;
                end else begin
                    state_d = boundary_next;
                end
            end
            T7: begin
                if (is_st) begin
                    mem_wait = 1'b1;
                    if (mem_ready) state_d = boundary_next;
                end else begin
                    state_d = boundary_next;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = T0;
        endcase
        timeout = mem_wait && !mem_ready && (cnt_q == CNT_LIMIT);
        if (timeout) state_d = HALT;
    end

    // Wait counter runs only while stalled in a memory state, otherwise rests at zero
    always_comb begin
        cnt_d     = '0;
        mem_err_d = mem_err_q | timeout;
        ir_d      = (state_q == T2) ? ir_in : ir_q;
        if (mem_wait && !mem_ready && !timeout) cnt_d = cnt_q + CNT_W'(1);
    end

    // Moore control word per microstep; forced quiet while clear is high
    always_comb begin
        ctl = '0;
        case (state_q)
            T0: begin
                ctl.pc_out = 1'b1;
                ctl.mar_in = 1'b1;
                ctl.op     = ALU_INC;
                ctl.z_in   = 1'b1;
            end
            T1: begin
                ctl.zlow_out = 1'b1;
                ctl.pc_in    = 1'b1;
                ctl.read     = 1'b1;
                ctl.mdr_in   = 1'b1;
            end
            T2: begin
                ctl.mdr_out = 1'b1;
                ctl.ir_in   = 1'b1;
            end
            T3: begin
                ctl.y_in    = 1'b1;
                ctl.reg_out = is_muldiv ? ra_oh : rb_oh;
            end
            T4: begin
                ctl.z_in = 1'b1;
                if (is_rtype) begin
                    ctl.reg_out = rc_oh;
                    ctl.op      = opc;
                end else if (is_muldiv) begin
                    ctl.reg_out = rb_oh;
                    ctl.op      = opc;
                end else begin
                    ctl.c_out = 1'b1;
                    ctl.op    = ALU_ADD;
                end
            end
            T5: begin
                ctl.zlow_out = 1'b1;
                if (is_rtype)       ctl.reg_in = ra_oh;
                else if (is_muldiv) ctl.lo_in  = 1'b1;
                else                ctl.mar_in = 1'b1;
            end
            T6: begin
                if (is_muldiv) begin
                    ctl.zhigh_out = 1'b1;
                    ctl.hi_in     = 1'b1;
                end else if (is_ld) begin
                    ctl.read   = 1'b1;
                    ctl.mdr_in = 1'b1;
                end else if (is_st) begin
                    ctl.reg_out = ra_oh;
                    ctl.mdr_in  = 1'b1;
                end
            end
            T7: begin
                if (is_ld) begin
                    ctl.mdr_out = 1'b1;
                    ctl.reg_in  = ra_oh;
                end else if (is_st) begin
                    ctl.write = 1'b1;
                end
            end
            default: ;
        endcase
        if (clear) ctl = '0;
    end

    assign reg_out   = ctl.reg_out;
    assign reg_in    = ctl.reg_in;
    assign HIout     = ctl.hi_out;
    assign LOout     = ctl.lo_out;
    assign Zhighout  = ctl.zhigh_out;
    assign Zlowout   = ctl.zlow_out;
    assign PCout     = ctl.pc_out;
    assign MDRout    = ctl.mdr_out;
    assign InPortout = ctl.inport_out;
    assign Yout      = ctl.y_out;
    assign Cout      = ctl.c_out;
    assign HIin      = ctl.hi_in;
    assign LOin      = ctl.lo_in;
    assign Zin       = ctl.z_in;
    assign PCin      = ctl.pc_in;
    assign MDRin     = ctl.mdr_in;
    assign MARin     = ctl.mar_in;
    assign IRin      = ctl.ir_in;
    assign Yin       = ctl.y_in;
    assign op        = ctl.op;
    assign Read      = ctl.read;
    assign Write     = ctl.write;
    assign c_sext    = clear ? 32'h0 : dec_c_sext;
    assign halted    = (state_q == HALT) && !clear;
    assign mem_err   = mem_err_q && !clear;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear, run, mem_ready;
    logic        step;
    logic [31:0] ir_in;
    logic [15:0] reg_out, reg_in;
    logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout, Cout;
    logic        HIin, LOin, Zin, PCin, MDRin, MARin, IRin, Yin;
    logic [4:0]  op;
    logic        Read, Write, halted, mem_err;
    logic [31:0] c_sext;

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [19:0] K_HIOUT = 20'h80000, K_LOOUT = 20'h40000, K_ZHOUT = 20'h20000,
                            K_ZLOUT = 20'h10000, K_PCOUT = 20'h08000, K_MDROUT = 20'h04000,
                            K_INPOUT = 20'h02000, K_YOUT = 20'h01000, K_COUT = 20'h00800,
                            K_HIIN = 20'h00400, K_LOIN = 20'h00200, K_ZIN = 20'h00100,
                            K_PCIN = 20'h00080, K_MDRIN = 20'h00040, K_MARIN = 20'h00020,
                            K_IRIN = 20'h00010, K_YIN = 20'h00008, K_RD = 20'h00004,
                            K_WR = 20'h00002, K_HLT = 20'h00001;

    wire [19:0] ctl = {HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout, Cout,
                       HIin, LOin, Zin, PCin, MDRin, MARin, IRin, Yin, Read, Write, halted};
    wire [56:0] obs = {reg_out, reg_in, op, ctl};

    control_sequencer dut (
        .clock     (clock),
        .clear     (clear),
        .run       (run),
`ifdef SINGLE_STEP_EN
        .step      (step),
`endif
        .ir_in     (ir_in),
        .mem_ready (mem_ready),
        .reg_out   (reg_out),
        .reg_in    (reg_in),
        .HIout     (HIout),
        .LOout     (LOout),
        .Zhighout  (Zhighout),
        .Zlowout   (Zlowout),
        .PCout     (PCout),
        .MDRout    (MDRout),
        .InPortout (InPortout),
        .Yout      (Yout),
        .Cout      (Cout),
        .HIin      (HIin),
        .LOin      (LOin),
        .Zin       (Zin),
        .PCin      (PCin),
        .MDRin     (MDRin),
        .MARin     (MARin),
        .IRin      (IRin),
        .Yin       (Yin),
        .op        (op),
        .Read      (Read),
        .Write     (Write),
        .c_sext    (c_sext),
        .halted    (halted),
        .mem_err   (mem_err)
    );

    always #5 clock = ~clock;

    function automatic logic [56:0] ex(input logic [15:0] ro, input logic [15:0] ri,
                                       input logic [4:0] o, input logic [19:0] c);
        return {ro, ri, o, c};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1: drive mem_ready, check this cycle's outputs, advance one clock
    task automatic cyc(input string tag, input logic mr, input logic [56:0] exp);
        mem_ready = mr;
        #1;
        check_eq(tag, {7'h0, obs}, {7'h0, exp});
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ir, input int dly);
        ir_in = 32'h0;
        cyc("t0", 1'b0, ex(16'h0, 16'h0, 5'b10110, K_PCOUT | K_MARIN | K_ZIN));
        for (int i = 0; i < dly; i++)
            cyc("t1_hold", 1'b0, ex(16'h0, 16'h0, 5'h0, K_ZLOUT | K_PCIN | K_RD | K_MDRIN));
        cyc("t1", 1'b1, ex(16'h0, 16'h0, 5'h0, K_ZLOUT | K_PCIN | K_RD | K_MDRIN));
        ir_in = ir;
        cyc("t2", 1'b0, ex(16'h0, 16'h0, 5'h0, K_MDROUT | K_IRIN));
        ir_in = 32'h0;
    endtask

    initial begin
        clear = 1'b1; run = 1'b1; mem_ready = 1'b0; ir_in = 32'h0; step = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_outs", {7'h0, obs}, 64'h0);
        check_eq("rst_csext", {32'h0, c_sext}, 64'h0);
        check_eq("rst_memerr", {63'h0, mem_err}, 64'h0);
        clear = 1'b0;

        // ld R5,0x40(R2) interrupted by clear while waiting in T6
        fetch(32'h02900040, 0);
        cyc("ld_t3", 1'b0, ex(16'h0004, 16'h0, 5'h0, K_YIN));
        check_eq("ld_csext", {32'h0, c_sext}, 64'h40);
        cyc("ld_t4", 1'b0, ex(16'h0, 16'h0, 5'b00011, K_COUT | K_ZIN));
        cyc("ld_t5", 1'b0, ex(16'h0, 16'h0, 5'h0, K_ZLOUT | K_MARIN));
        cyc("ld_t6", 1'b0, ex(16'h0, 16'h0, 5'h0, K_RD | K_MDRIN));
        clear = 1'b1;
        #1;
        check_eq("clr_memerr", {63'h0, mem_err}, 64'h0);
        cyc("clr_t6", 1'b0, 57'h0);
        clear = 1'b0;

        // add R3,R1,R2 with two wait cycles in T1
        fetch(32'h19890000, 2);
        cyc("add_t3", 1'b0, ex(16'h0002, 16'h0, 5'h0, K_YIN));
        cyc("add_t4", 1'b0, ex(16'h0004, 16'h0, 5'b00011, K_ZIN));
        cyc("add_t5", 1'b0, ex(16'h0, 16'h0008, 5'h0, K_ZLOUT));

        // ld R5,0x40(R2) complete, one wait cycle in T6
        fetch(32'h02900040, 0);
        cyc("ld2_t3", 1'b0, ex(16'h0004, 16'h0, 5'h0, K_YIN));
        cyc("ld2_t4", 1'b0, ex(16'h0, 16'h0, 5'b00011, K_COUT | K_ZIN));
        cyc("ld2_t5", 1'b0, ex(16'h0, 16'h0, 5'h0, K_ZLOUT | K_MARIN));
        cyc("ld2_t6w", 1'b0, ex(16'h0, 16'h0, 5'h0, K_RD | K_MDRIN));
        cyc("ld2_t6", 1'b1, ex(16'h0, 16'h0, 5'h0, K_RD | K_MDRIN));
        cyc("ld2_t7", 1'b0, ex(16'h0, 16'h0020, 5'h0, K_MDROUT));

        // st R1,0x40000(R0): negative displacement, Write held until mem_ready
        fetch(32'h10840000, 0);
        cyc("st_t3", 1'b0, ex(16'h0001, 16'h0, 5'h0, K_YIN));
        check_eq("st_csext", {32'h0, c_sext}, 64'hFFFC0000);
        cyc("st_t4", 1'b0, ex(16'h0, 16'h0, 5'b00011, K_COUT | K_ZIN));
        cyc("st_t5", 1'b0, ex(16'h0, 16'h0, 5'h0, K_ZLOUT | K_MARIN));
        cyc("st_t6", 1'b0, ex(16'h0002, 16'h0, 5'h0, K_MDRIN));
        cyc("st_t7w0", 1'b0, ex(16'h0, 16'h0, 5'h0, K_WR));
        cyc("st_t7w1", 1'b0, ex(16'h0, 16'h0, 5'h0, K_WR));
        cyc("st_t7", 1'b1, ex(16'h0, 16'h0, 5'h0, K_WR));

        // mul R4,R6,R7
        fetch(32'h7A338000, 0);
        cyc("mul_t3", 1'b0, ex(16'h0010, 16'h0, 5'h0, K_YIN));
        cyc("mul_t4", 1'b0, ex(16'h0040, 16'h0, 5'b01111, K_ZIN));
        cyc("mul_t5", 1'b0, ex(16'h0, 16'h0, 5'h0, K_ZLOUT | K_LOIN));
        cyc("mul_t6", 1'b0, ex(16'h0, 16'h0, 5'h0, K_ZHOUT | K_HIIN));

        // unknown opcode 11111 acts as nop; then nop with run=0 parks in IDLE
        fetch(32'hF8000000, 0);
        run = 1'b0;
        fetch(32'hC0000000, 0);
        cyc("idle0", 1'b0, 57'h0);
        cyc("idle1", 1'b0, 57'h0);
        run = 1'b1;
        cyc("idle_go", 1'b0, 57'h0);

        // halt stays halted until clear
        fetch(32'hD8000000, 0);
        cyc("halt0", 1'b0, ex(16'h0, 16'h0, 5'h0, K_HLT));
        cyc("halt1", 1'b1, ex(16'h0, 16'h0, 5'h0, K_HLT));
        check_eq("halt_memerr", {63'h0, mem_err}, 64'h0);
        clear = 1'b1;
        cyc("halt_clr", 1'b0, 57'h0);
        clear = 1'b0;

        // mem_ready on the limit cycle still completes the fetch
        cyc("lim_t0", 1'b0, ex(16'h0, 16'h0, 5'b10110, K_PCOUT | K_MARIN | K_ZIN));
        for (int i = 0; i < 14; i++)
            cyc("lim_t1w", 1'b0, ex(16'h0, 16'h0, 5'h0, K_ZLOUT | K_PCIN | K_RD | K_MDRIN));
        cyc("lim_t1", 1'b1, ex(16'h0, 16'h0, 5'h0, K_ZLOUT | K_PCIN | K_RD | K_MDRIN));
        ir_in = 32'hC0000000;
        cyc("lim_t2", 1'b0, ex(16'h0, 16'h0, 5'h0, K_MDROUT | K_IRIN));
        check_eq("lim_memerr", {63'h0, mem_err}, 64'h0);

        // no mem_ready for 15 cycles: timeout into HALT with sticky mem_err
        cyc("to_t0", 1'b0, ex(16'h0, 16'h0, 5'b10110, K_PCOUT | K_MARIN | K_ZIN));
        for (int i = 0; i < 15; i++)
            cyc("to_t1w", 1'b0, ex(16'h0, 16'h0, 5'h0, K_ZLOUT | K_PCIN | K_RD | K_MDRIN));
        check_eq("to_memerr", {63'h0, mem_err}, 64'h1);
        cyc("to_halt0", 1'b1, ex(16'h0, 16'h0, 5'h0, K_HLT));
        cyc("to_halt1", 1'b0, ex(16'h0, 16'h0, 5'h0, K_HLT));
        check_eq("to_memerr_hold", {63'h0, mem_err}, 64'h1);
        clear = 1'b1;
        cyc("to_clr", 1'b0, 57'h0);
        clear = 1'b0;
        #1;
        check_eq("to_memerr_clr", {63'h0, mem_err}, 64'h0);
        cyc("to_after_t0", 1'b0, ex(16'h0, 16'h0, 5'b10110, K_PCOUT | K_MARIN | K_ZIN));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
